// File: rtl/mc_port_arbiter_if.sv
// Memory-controller side of the port arbiter: request bus toward the MC and
// response bus back from it, with the arbiter as master and the MC as slave.
interface mc_port_arbiter_if #(
  parameter int MC_RTNCTL_WIDTH = 32
);
  // Handshake: a request transfers on every clock where mc_rq_vld is high and
  // mc_rq_stall is low; a response transfers where mc_rs_vld is high and
  // mc_rs_stall is low. Payload must stay stable while valid and stalled.
  logic                       mc_rq_vld;
  logic [2:0]                 mc_rq_cmd;
  logic [1:0]                 mc_rq_size;
  logic [47:0]                mc_rq_vadr;
  logic [63:0]                mc_rq_data;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic                       mc_rq_stall;
  logic                       mc_rs_vld;
  logic [2:0]                 mc_rs_cmd;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic [63:0]                mc_rs_data;
  logic                       mc_rs_stall;

  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
    input  mc_rq_stall,
    input  mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl, mc_rs_data,
    output mc_rs_stall
  );

  modport slave (
    input  mc_rq_vld, mc_rq_cmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
    output mc_rq_stall,
    output mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl, mc_rs_data,
    input  mc_rs_stall
  );
endinterface

// File: rtl/mc_port_arbiter.sv
// Shares one MC request/response port among NUM_CORE cores: round-robin grant
// into a single stall-holding register stage, rtnctl tagging and response routing.
module mc_port_arbiter #(
  parameter int NUM_CORE        = 4,
  parameter int NB_COREID       = 2,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int MAX_OUTST       = 8,
  parameter int NB_OUTST        = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CORE-1:0]                 core_rq_vld,
  input  logic [3*NUM_CORE-1:0]               core_rq_cmd,
  input  logic [2*NUM_CORE-1:0]               core_rq_size,
  input  logic [48*NUM_CORE-1:0]              core_rq_vadr,
  input  logic [64*NUM_CORE-1:0]              core_rq_data,
  input  logic [MC_RTNCTL_WIDTH*NUM_CORE-1:0] core_rq_rtnctl,
  output logic [NUM_CORE-1:0]                 core_rq_gnt,
  mc_port_arbiter_if.master                   mc,
  output logic [NUM_CORE-1:0]                 core_rs_vld,
  output logic [2:0]                          core_rs_cmd,
  output logic [MC_RTNCTL_WIDTH-1:0]          core_rs_rtnctl,
  output logic [63:0]                         core_rs_data,
  input  logic [NUM_CORE-1:0]                 core_rs_stall,
  output logic                                idle,
  output logic                                tag_err
);
  localparam int TAG_LSB = MC_RTNCTL_WIDTH - NB_COREID;

  logic [NB_OUTST-1:0]  outst [NUM_CORE];
  logic [NB_COREID-1:0] ptr;
  logic [NB_COREID-1:0] gnt_idx;
  logic [NB_COREID-1:0] tgt;
  logic [NUM_CORE-1:0]  eligible;
  logic [NUM_CORE-1:0]  inc;
  logic [NUM_CORE-1:0]  dec;
  logic [NUM_CORE-1:0]  zero;
  logic                 slot_free;
  logic                 found;
  logic                 gnt_vld;
  logic                 deliver;

  assign slot_free = !mc.mc_rq_vld || !mc.mc_rq_stall;

  // Saturated cores drop out of the search instead of blocking the pointer.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CORE; i++)
      eligible[i] = core_rq_vld[i] && (outst[i] < NB_OUTST'(MAX_OUTST));
  end

  always_comb begin
    int                   idx;
    logic [NB_COREID-1:0] idx_c;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CORE; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CORE) idx = idx - NUM_CORE;
      idx_c = NB_COREID'(idx);
      if (!found && eligible[idx_c]) begin
        found   = 1'b1;
        gnt_idx = idx_c;
      end
    end
  end

  // No grant while reset is held: the core would believe its request was taken.
  assign gnt_vld = found && slot_free && rst_n;

  always_comb begin
    core_rq_gnt = '0;
    if (gnt_vld) core_rq_gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc.mc_rq_vld    <= 1'b0;
      mc.mc_rq_cmd    <= '0;
      mc.mc_rq_size   <= '0;
      mc.mc_rq_vadr   <= '0;
      mc.mc_rq_data   <= '0;
      mc.mc_rq_rtnctl <= '0;
      ptr             <= '0;
    end else if (gnt_vld) begin
      mc.mc_rq_vld    <= 1'b1;
      mc.mc_rq_cmd    <= core_rq_cmd[gnt_idx*3 +: 3];
      mc.mc_rq_size   <= core_rq_size[gnt_idx*2 +: 2];
      mc.mc_rq_vadr   <= core_rq_vadr[gnt_idx*48 +: 48];
      mc.mc_rq_data   <= core_rq_data[gnt_idx*64 +: 64];
      mc.mc_rq_rtnctl <= {gnt_idx, core_rq_rtnctl[gnt_idx*MC_RTNCTL_WIDTH +: TAG_LSB]};
      ptr             <= (gnt_idx == NB_COREID'(NUM_CORE - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (slot_free) begin
      mc.mc_rq_vld <= 1'b0;
    end
  end

  // Responses route by the core tag that the request side placed in rtnctl.
  assign tgt            = mc.mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: NB_COREID];
  assign mc.mc_rs_stall = mc.mc_rs_vld && core_rs_stall[tgt];
  assign deliver        = mc.mc_rs_vld && !mc.mc_rs_stall;
  assign core_rs_cmd    = mc.mc_rs_cmd;
  assign core_rs_rtnctl = mc.mc_rs_rtnctl;
  assign core_rs_data   = mc.mc_rs_data;

  always_comb begin
    core_rs_vld      = '0;
    core_rs_vld[tgt] = mc.mc_rs_vld;
  end

  always_comb begin
    inc  = '0;
    dec  = '0;
    zero = '0;
    idle = !mc.mc_rq_vld;
    for (int i = 0; i < NUM_CORE; i++) begin
      inc[i]  = gnt_vld && (gnt_idx == NB_COREID'(i));
      dec[i]  = deliver && (tgt == NB_COREID'(i));
      zero[i] = (outst[i] == '0);
      if (!zero[i]) idle = 1'b0;
    end
  end

  // A simultaneous grant and delivery to one core cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CORE; i++) outst[i] <= '0;
      tag_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORE; i++) begin
        if (inc[i] && !dec[i])
          outst[i] <= outst[i] + 1'b1;
        else if (dec[i] && !inc[i] && !zero[i])
          outst[i] <= outst[i] - 1'b1;
      end
      if (|(dec & zero)) tag_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter: a request-stream scoreboard plus
// point checks on grants, response routing, counters, idle, tag_err and reset.
module tb_mc_port_arbiter;
  localparam int NC = 4;
  localparam int W  = 32;
  localparam int TW = 149;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]   core_rq_vld;
  logic [3*NC-1:0] core_rq_cmd;
  logic [2*NC-1:0] core_rq_size;
  logic [48*NC-1:0] core_rq_vadr;
  logic [64*NC-1:0] core_rq_data;
  logic [W*NC-1:0] core_rq_rtnctl;
  logic [NC-1:0]   core_rq_gnt;
  logic [NC-1:0]   core_rs_vld;
  logic [2:0]      core_rs_cmd;
  logic [W-1:0]    core_rs_rtnctl;
  logic [63:0]     core_rs_data;
  logic [NC-1:0]   core_rs_stall;
  logic            idle;
  logic            tag_err;

  logic [2:0]  c_cmd    [NC];
  logic [1:0]  c_size   [NC];
  logic [47:0] c_vadr   [NC];
  logic [63:0] c_data   [NC];
  logic [W-1:0] c_rtnctl [NC];

  assign core_rq_cmd    = {c_cmd[3], c_cmd[2], c_cmd[1], c_cmd[0]};
  assign core_rq_size   = {c_size[3], c_size[2], c_size[1], c_size[0]};
  assign core_rq_vadr   = {c_vadr[3], c_vadr[2], c_vadr[1], c_vadr[0]};
  assign core_rq_data   = {c_data[3], c_data[2], c_data[1], c_data[0]};
  assign core_rq_rtnctl = {c_rtnctl[3], c_rtnctl[2], c_rtnctl[1], c_rtnctl[0]};

  mc_port_arbiter_if #(.MC_RTNCTL_WIDTH(W)) mc_if ();

  mc_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_rq_vld    (core_rq_vld),
    .core_rq_cmd    (core_rq_cmd),
    .core_rq_size   (core_rq_size),
    .core_rq_vadr   (core_rq_vadr),
    .core_rq_data   (core_rq_data),
    .core_rq_rtnctl (core_rq_rtnctl),
    .core_rq_gnt    (core_rq_gnt),
    .mc             (mc_if.master),
    .core_rs_vld    (core_rs_vld),
    .core_rs_cmd    (core_rs_cmd),
    .core_rs_rtnctl (core_rs_rtnctl),
    .core_rs_data   (core_rs_data),
    .core_rs_stall  (core_rs_stall),
    .idle           (idle),
    .tag_err        (tag_err)
  );

  // scoreboard
  logic [TW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] exp_txn(input int c);
    logic [1:0] ci;
    ci = 2'(c);
    return {ci, c_rtnctl[ci][W-3:0], c_vadr[ci], c_cmd[ci], c_size[ci], c_data[ci]};
  endfunction

  function automatic logic [3:0] one_hot(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return v;
  endfunction

  task automatic monitor_loop();
    logic [TW-1:0] got;
    logic [TW-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && mc_if.mc_rq_vld && !mc_if.mc_rq_stall) begin
        got = {mc_if.mc_rq_rtnctl, mc_if.mc_rq_vadr, mc_if.mc_rq_cmd,
               mc_if.mc_rq_size, mc_if.mc_rq_data};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rq_txn unexpected got=%h at %0t", got, $time);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL rq_txn got=%h exp=%h at %0t", got, exp, $time);
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_rs(input logic [1:0] tag);
    mc_if.mc_rs_vld    = 1'b1;
    mc_if.mc_rs_rtnctl = {tag, 30'h0000_0ABC};
    mc_if.mc_rs_cmd    = 3'd2;
    mc_if.mc_rs_data   = 64'hFEED_0000_0000_0000 | 64'(tag);
    tick();
    mc_if.mc_rs_vld = 1'b0;
  endtask

  initial begin
    core_rq_vld        = '0;
    core_rs_stall      = '0;
    mc_if.mc_rq_stall  = 1'b0;
    mc_if.mc_rs_vld    = 1'b0;
    mc_if.mc_rs_cmd    = '0;
    mc_if.mc_rs_rtnctl = '0;
    mc_if.mc_rs_data   = '0;
    c_rtnctl[0] = 32'hC000_0005; c_rtnctl[1] = 32'h8000_0116;
    c_rtnctl[2] = 32'h4000_0227; c_rtnctl[3] = 32'hFFFF_F338;
    c_vadr[0] = 48'h0000_AAAA_0000; c_vadr[1] = 48'h0001_BBBB_0040;
    c_vadr[2] = 48'h0002_CCCC_0080; c_vadr[3] = 48'h0003_DDDD_00C0;
    c_data[0] = 64'hD000_0000_0000_00A0; c_data[1] = 64'hD111_1111_1111_11A1;
    c_data[2] = 64'hD222_2222_2222_22A2; c_data[3] = 64'hD333_3333_3333_33A3;
    c_cmd[0] = 3'd1; c_cmd[1] = 3'd2; c_cmd[2] = 3'd3; c_cmd[3] = 3'd4;
    c_size[0] = 2'd0; c_size[1] = 2'd1; c_size[2] = 2'd2; c_size[3] = 2'd3;
    fork
      monitor_loop();
    join_none

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_mc_rq_vld", 64'(mc_if.mc_rq_vld), 64'(0));
    check("rst_gnt", 64'(core_rq_gnt), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_tag_err", 64'(tag_err), 64'(0));
    check("rst_rtnctl", 64'(mc_if.mc_rq_rtnctl), 64'(0));
    check("rst_vadr", 64'(mc_if.mc_rq_vadr), 64'(0));
    check("rst_rs_stall", 64'(mc_if.mc_rs_stall), 64'(0));
    tick();

    // round robin, all cores requesting
    core_rq_vld = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_gnt", 64'(core_rq_gnt), 64'(one_hot(k % 4)));
      if (k > 0) check("rr_vld_cont", 64'(mc_if.mc_rq_vld), 64'(1));
      exp_q.push_back(exp_txn(k % 4));
      tick();
    end
    core_rq_vld = '0;
    @(negedge clk);
    check("rr_gnt_none", 64'(core_rq_gnt), 64'(0));
    check("rr_vld_last", 64'(mc_if.mc_rq_vld), 64'(1));
    tick();
    @(negedge clk);
    check("rr_drained", 64'(mc_if.mc_rq_vld), 64'(0));
    check("rr_not_idle", 64'(idle), 64'(0));
    tick();

    // stall holds the stage
    c_vadr[2] = 48'h0000_0000_1000;
    core_rq_vld = 4'b0100;
    mc_if.mc_rq_stall = 1'b1;
    @(negedge clk);
    check("stall_gnt2", 64'(core_rq_gnt), 64'(4'b0100));
    exp_q.push_back(exp_txn(2));
    tick();
    core_rq_vld = 4'b1001;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_vld", 64'(mc_if.mc_rq_vld), 64'(1));
      check("stall_vadr", 64'(mc_if.mc_rq_vadr), 64'(48'h1000));
      check("stall_no_gnt", 64'(core_rq_gnt), 64'(0));
      tick();
    end
    mc_if.mc_rq_stall = 1'b0;
    @(negedge clk);
    check("resume_gnt3", 64'(core_rq_gnt), 64'(4'b1000));
    exp_q.push_back(exp_txn(3));
    tick();
    @(negedge clk);
    check("resume_gnt0", 64'(core_rq_gnt), 64'(4'b0001));
    exp_q.push_back(exp_txn(0));
    tick();
    core_rq_vld = '0;
    repeat (2) tick();

    // response to core 3 under core back-pressure
    mc_if.mc_rs_vld    = 1'b1;
    mc_if.mc_rs_rtnctl = 32'hC000_0077;
    mc_if.mc_rs_cmd    = 3'd6;
    mc_if.mc_rs_data   = 64'h0123_4567_89AB_CDEF;
    core_rs_stall      = 4'b1000;
    @(negedge clk);
    check("rs_stall", 64'(mc_if.mc_rs_stall), 64'(1));
    check("rs_vld_onehot", 64'(core_rs_vld), 64'(4'b1000));
    check("rs_data_bcast", core_rs_data, 64'h0123_4567_89AB_CDEF);
    check("rs_cmd_bcast", 64'(core_rs_cmd), 64'(3'd6));
    tick();
    @(negedge clk);
    check("rs_outst3_held", 64'(dut.outst[3]), 64'(3));
    core_rs_stall = '0;
    #1;
    check("rs_stall_rel", 64'(mc_if.mc_rs_stall), 64'(0));
    tick();
    mc_if.mc_rs_vld = 1'b0;
    @(negedge clk);
    check("rs_outst3_dec", 64'(dut.outst[3]), 64'(2));
    tick();

    // grant and delivery to core 0 in one cycle
    send_rs(2'd0);
    core_rq_vld        = 4'b0001;
    mc_if.mc_rs_vld    = 1'b1;
    mc_if.mc_rs_rtnctl = 32'h0000_0011;
    @(negedge clk);
    check("same_gnt0", 64'(core_rq_gnt), 64'(4'b0001));
    check("same_rs0", 64'(core_rs_vld), 64'(4'b0001));
    exp_q.push_back(exp_txn(0));
    tick();
    core_rq_vld     = '0;
    mc_if.mc_rs_vld = 1'b0;
    @(negedge clk);
    check("same_outst0", 64'(dut.outst[0]), 64'(2));
    check("same_not_idle", 64'(idle), 64'(0));
    tick();

    // drain all outstanding, then a stray response
    repeat (2) send_rs(2'd0);
    repeat (2) send_rs(2'd1);
    repeat (3) send_rs(2'd2);
    repeat (2) send_rs(2'd3);
    @(negedge clk);
    check("drain_idle", 64'(idle), 64'(1));
    check("drain_tag_err", 64'(tag_err), 64'(0));
    tick();
    send_rs(2'd2);
    @(negedge clk);
    check("stray_tag_err", 64'(tag_err), 64'(1));
    check("stray_outst2", 64'(dut.outst[2]), 64'(0));
    repeat (3) tick();
    @(negedge clk);
    check("tag_err_sticky", 64'(tag_err), 64'(1));

    // saturation of core 1
    tick();
    do_reset();
    @(negedge clk);
    check("rst2_tag_err", 64'(tag_err), 64'(0));
    tick();
    core_rq_vld = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("sat_gnt1", 64'(core_rq_gnt), 64'(4'b0010));
      exp_q.push_back(exp_txn(1));
      tick();
    end
    @(negedge clk);
    check("sat_9th_blocked", 64'(core_rq_gnt), 64'(0));
    tick();
    core_rq_vld = 4'b1010;
    @(negedge clk);
    check("sat_gnt3", 64'(core_rq_gnt), 64'(4'b1000));
    exp_q.push_back(exp_txn(3));
    tick();
    core_rq_vld        = 4'b0010;
    mc_if.mc_rs_vld    = 1'b1;
    mc_if.mc_rs_rtnctl = 32'h4000_0001;
    @(negedge clk);
    check("sat_still_blocked", 64'(core_rq_gnt), 64'(0));
    check("sat_rs_vld1", 64'(core_rs_vld), 64'(4'b0010));
    tick();
    mc_if.mc_rs_vld = 1'b0;
    @(negedge clk);
    check("sat_regrant1", 64'(core_rq_gnt), 64'(4'b0010));
    exp_q.push_back(exp_txn(1));
    tick();
    core_rq_vld = '0;
    repeat (2) tick();

    // reset in the middle of a burst
    send_rs(2'd0);
    @(negedge clk);
    check("pre_rst_tag_err", 64'(tag_err), 64'(1));
    tick();
    core_rq_vld = 4'hF;
    @(negedge clk);
    check("burst_gnt2", 64'(core_rq_gnt), 64'(4'b0100));
    exp_q.push_back(exp_txn(2));
    tick();
    @(negedge clk);
    check("burst_gnt3", 64'(core_rq_gnt), 64'(4'b1000));
    exp_q.push_back(exp_txn(3));
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(mc_if.mc_rq_vld), 64'(0));
    check("mid_rst_gnt", 64'(core_rq_gnt), 64'(0));
    check("mid_rst_idle", 64'(idle), 64'(1));
    check("mid_rst_tag_err", 64'(tag_err), 64'(0));
    check("mid_rst_vadr", 64'(mc_if.mc_rq_vadr), 64'(0));
    check("mid_rst_rtnctl", 64'(mc_if.mc_rq_rtnctl), 64'(0));
    check("mid_rst_dropped", 64'(exp_q.size()), 64'(1));
    exp_q.delete();
    core_rq_vld = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
